// File: rtl/coprime_if.sv
// coprime_if: request/response bundle between two requesters,
// the shared GCD engine and the result consumer.
interface coprime_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_gcd;
  logic             rsp_coprime;
  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_gcd,
    input  rsp_coprime, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_gcd,
    output rsp_coprime, busy
  );
endinterface

// File: rtl/coprime_sched.sv
// coprime_sched: round-robin front end for two requesters
// sharing one iterative binary-GCD (Stein) engine.
module coprime_sched #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  coprime_if.slave bus
);
  localparam int KW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_gcd;
  logic [KW-1:0]    r_k;
  logic             r_id;
  logic             r_last;
  logic             r_rsp_valid;
  logic             r_cop;

  logic             w_g0;
  logic             w_g1;
  logic [WIDTH-1:0] w_ab;
  logic [WIDTH-1:0] w_ba;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_sh;

  assign w_ab = r_a - r_b;
  assign w_ba = r_b - r_a;
  assign w_or = r_a | r_b;
  assign w_sh = r_a << r_k;

  // On contention the requester not granted last time wins.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (r_state == S_IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_g0 = r_last;
        w_g1 = !r_last;
      end else begin
        w_g0 = bus.req0_valid;
        w_g1 = bus.req1_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_gcd       <= '0;
      r_k         <= '0;
      r_id        <= 1'b0;
      r_last      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_cop       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_g0 || w_g1) begin
            r_a     <= w_g1 ? bus.req1_a : bus.req0_a;
            r_b     <= w_g1 ? bus.req1_b : bus.req0_b;
            r_k     <= '0;
            r_id    <= w_g1;
            r_last  <= w_g1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_a == '0 || r_b == '0) begin
            r_gcd       <= w_or;
            r_cop       <= (w_or == WIDTH'(1));
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_a == r_b) begin
            r_gcd       <= w_sh;
            r_cop       <= (w_sh == WIDTH'(1));
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (!r_a[0] && !r_b[0]) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
            r_k <= r_k + KW'(1);
          end else if (!r_a[0]) begin
            r_a <= r_a >> 1;
          end else if (!r_b[0]) begin
            r_b <= r_b >> 1;
          end else if (r_a > r_b) begin
            r_a <= w_ab >> 1;
          end else begin
            r_b <= w_ba >> 1;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = w_g0;
  assign bus.req1_ready  = w_g1;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_id      = r_id;
  assign bus.rsp_gcd     = r_gcd;
  assign bus.rsp_coprime = r_cop;
  assign bus.busy        = (r_state != S_IDLE);
endmodule
